// File: rtl/ether_frame_tx.sv
// Ethernet frame transmitter: serialises one packed frame MSB-byte-first
// onto an 8-bit valid/ready stream, then holds off for the inter-frame gap.
module ether_frame_tx #(
  parameter int FRAME_W   = 576,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic               busy,
  output logic [CNT_W-1:0]   frames_sent
);

  localparam int NBYTES = FRAME_W / 8;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);
  localparam logic [GW-1:0] GAP_INIT =
    (IFG_BYTES > 0) ? GW'(IFG_BYTES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   frames_sent_q, frames_sent_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frames_sent_d = frames_sent_q;
    frame_ready   = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_sof        = 1'b0;
    tx_eof        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Held low during reset so nothing is accepted before release.
        frame_ready = rst_n;
        if (frame_valid && rst_n) begin
          shreg_d    = frame_in;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[FRAME_W-1 -: 8];
        tx_sof   = (byte_cnt_q == '0);
        tx_eof   = (byte_cnt_q == LAST);
        if (tx_ready) begin
          shreg_d    = shreg_q << 8;
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == LAST) begin
            byte_cnt_d    = '0;
            frames_sent_d = frames_sent_q + CNT_W'(1);
            if (IFG_BYTES > 0) begin
              gap_cnt_d = GAP_INIT;
              state_d   = GAP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign frames_sent = frames_sent_q;

endmodule
